// File: rtl/mem_access_unit_if.sv
// Request/response and bus handshake bundle for mem_access_unit.
// slave = the load/store unit itself, master = the pipeline/bus environment.
interface mem_access_unit_if #(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32
);
   localparam int BE_WIDTH = DATA_WIDTH / 8;

   // pipeline request
   logic                  req_valid;
   logic                  req_ready;
   logic [1:0]            req_type;
   logic [2:0]            req_size;
   logic                  req_signed;
   logic [ADDR_WIDTH-1:0] req_addr;
   logic [31:0]           req_wdata;

   // bus port
   logic                  bus_req;
   logic                  bus_we;
   logic [BE_WIDTH-1:0]   bus_be;
   logic [ADDR_WIDTH-1:0] bus_addr;
   logic [DATA_WIDTH-1:0] bus_wdata;
   logic                  bus_ack;
   logic [DATA_WIDTH-1:0] bus_rdata;

   // response
   logic                  resp_valid;
   logic [31:0]           resp_data;
   logic                  resp_addr_err;
   logic                  resp_bus_err;
   logic                  busy;

   modport slave (
      input  req_valid, req_type, req_size, req_signed, req_addr, req_wdata,
      input  bus_ack, bus_rdata,
      output req_ready, bus_req, bus_we, bus_be, bus_addr, bus_wdata,
      output resp_valid, resp_data, resp_addr_err, resp_bus_err, busy
   );

   modport master (
      output req_valid, req_type, req_size, req_signed, req_addr, req_wdata,
      output bus_ack, bus_rdata,
      input  req_ready, bus_req, bus_we, bus_be, bus_addr, bus_wdata,
      input  resp_valid, resp_data, resp_addr_err, resp_bus_err, busy
   );
endinterface

// File: rtl/mem_access_unit.sv
// Multi-cycle load/store unit: alignment check, byte-lane steering for
// stores, load extension / LWL-LWR merge, bus hold with timeout.
module mem_access_unit #(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32,
   parameter int TIMEOUT    = 255
) (
   input  logic             clk,
   input  logic             rst,
   mem_access_unit_if.slave mif
);
   localparam int BE_WIDTH = DATA_WIDTH / 8;
   localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ~ADDR_WIDTH'(BE_WIDTH - 1);
   localparam bit WIDE = (DATA_WIDTH == 64);

   typedef enum logic [1:0] {S_IDLE, S_BUS, S_RESP} state_t;
   typedef enum logic [2:0] {
      SZ_BYTE  = 3'd0,
      SZ_HALF  = 3'd1,
      SZ_FULL  = 3'd2,
      SZ_LEFT  = 3'd3,
      SZ_RIGHT = 3'd4
   } size_t;

   // latched request
   state_t      r_state;
   logic [31:0] r_cnt;
   logic        r_store;
   size_t       r_size;
   logic        r_signed;
   logic [1:0]  r_o;
   logic        r_hi;
   logic [31:0] r_rt;
   logic [31:0] r_addr32;

   // request decode
   logic                  w_load;
   logic                  w_store;
   logic                  w_misal;
   logic                  w_hi;
   size_t                 w_size;
   logic [1:0]            w_o;
   logic [1:0]            w_lsh;
   logic [3:0]            w_be4;
   logic [31:0]           w_wd32;
   logic [BE_WIDTH-1:0]   w_be;
   logic [DATA_WIDTH-1:0] w_wd;

   // load path
   logic [5:0]  w_rsh;
   logic [31:0] w_rd;
   logic [7:0]  w_b;
   logic [15:0] w_h;
   logic [31:0] w_res;
   logic        w_tmo;

   // Decode the incoming request and build the lane-positioned store image.
   always_comb begin
      w_load  = (mif.req_type == 2'd1);
      w_store = (mif.req_type == 2'd2);
      w_size  = (mif.req_size > 3'd4) ? SZ_FULL : size_t'(mif.req_size);
      w_o     = mif.req_addr[1:0];
      w_lsh   = 2'd3 - w_o;
      w_hi    = WIDE && mif.req_addr[2];
      w_misal = ((w_size == SZ_HALF) && w_o[0]) ||
                ((w_size == SZ_FULL) && (w_o != 2'd0));
      w_be4   = 4'b1111;
      w_wd32  = mif.req_wdata;
      case (w_size)
         SZ_BYTE: begin
            w_be4  = 4'b0001 << w_o;
            w_wd32 = {4{mif.req_wdata[7:0]}};
         end
         SZ_HALF: begin
            w_be4  = w_o[1] ? 4'b1100 : 4'b0011;
            w_wd32 = {2{mif.req_wdata[15:0]}};
         end
         // SWL: the top (o+1) bytes of rt land in the low lanes
         SZ_LEFT: begin
            w_be4  = 4'b1111 >> w_lsh;
            w_wd32 = mif.req_wdata >> {w_lsh, 3'b000};
         end
         // SWR: rt slides up by o bytes
         SZ_RIGHT: begin
            w_be4  = 4'b1111 << w_o;
            w_wd32 = mif.req_wdata << {w_o, 3'b000};
         end
         default: ;
      endcase
      // 64-bit bus: upper word lanes when addr[2] is set
      w_be = BE_WIDTH'(w_be4) << (w_hi ? 3'd4 : 3'd0);
      w_wd = DATA_WIDTH'(w_wd32) << (w_hi ? 6'd32 : 6'd0);
   end

   // Select the addressed word of the bus and form the load result.
   always_comb begin
      w_rsh = {r_hi, 5'b00000};
      w_rd  = 32'(mif.bus_rdata >> w_rsh);
      w_b   = w_rd[{r_o, 3'b000} +: 8];
      w_h   = w_rd[{r_o[1], 4'b0000} +: 16];
      w_res = w_rd;
      case (r_size)
         SZ_BYTE: w_res = {{24{r_signed & w_b[7]}}, w_b};
         SZ_HALF: w_res = {{16{r_signed & w_h[15]}}, w_h};
         SZ_LEFT: begin
            case (r_o)
               2'd0:    w_res = {w_rd[7:0],  r_rt[23:0]};
               2'd1:    w_res = {w_rd[15:0], r_rt[15:0]};
               2'd2:    w_res = {w_rd[23:0], r_rt[7:0]};
               default: w_res = w_rd;
            endcase
         end
         SZ_RIGHT: begin
            case (r_o)
               2'd0:    w_res = w_rd;
               2'd1:    w_res = {r_rt[31:24], w_rd[31:8]};
               2'd2:    w_res = {r_rt[31:16], w_rd[31:16]};
               default: w_res = {r_rt[31:8],  w_rd[31:24]};
            endcase
         end
         default: ;
      endcase
      // count reaching TIMEOUT on this cycle; ack still takes priority
      w_tmo = (TIMEOUT != 0) && (r_cnt == 32'(TIMEOUT - 1));
   end

   // Transaction FSM with all handshake/bus/response outputs registered.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state           <= S_IDLE;
         r_cnt             <= '0;
         r_store           <= 1'b0;
         r_size            <= SZ_FULL;
         r_signed          <= 1'b0;
         r_o               <= '0;
         r_hi              <= 1'b0;
         r_rt              <= '0;
         r_addr32          <= '0;
         mif.req_ready     <= 1'b1;
         mif.busy          <= 1'b0;
         mif.bus_req       <= 1'b0;
         mif.bus_we        <= 1'b0;
         mif.bus_be        <= '0;
         mif.bus_addr      <= '0;
         mif.bus_wdata     <= '0;
         mif.resp_valid    <= 1'b0;
         mif.resp_data     <= '0;
         mif.resp_addr_err <= 1'b0;
         mif.resp_bus_err  <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (mif.req_valid) begin
                  r_store       <= w_store;
                  r_size        <= w_size;
                  r_signed      <= mif.req_signed;
                  r_o           <= w_o;
                  r_hi          <= w_hi;
                  r_rt          <= mif.req_wdata;
                  r_addr32      <= 32'(mif.req_addr);
                  r_cnt         <= '0;
                  mif.req_ready <= 1'b0;
                  mif.busy      <= 1'b1;
                  if ((w_load || w_store) && !w_misal) begin
                     r_state       <= S_BUS;
                     mif.bus_req   <= 1'b1;
                     mif.bus_we    <= w_store;
                     mif.bus_be    <= w_store ? w_be : '0;
                     mif.bus_addr  <= mif.req_addr & ALIGN_MASK;
                     mif.bus_wdata <= w_store ? w_wd : '0;
                  end else begin
                     // NOOP or misaligned: answer without touching the bus
                     r_state           <= S_RESP;
                     mif.resp_valid    <= 1'b1;
                     mif.resp_data     <= 32'(mif.req_addr);
                     mif.resp_addr_err <= w_load || w_store;
                     mif.resp_bus_err  <= 1'b0;
                  end
               end
            end
            S_BUS: begin
               if (mif.bus_ack || w_tmo) begin
                  r_state           <= S_RESP;
                  mif.bus_req       <= 1'b0;
                  mif.bus_we        <= 1'b0;
                  mif.bus_be        <= '0;
                  mif.resp_valid    <= 1'b1;
                  mif.resp_addr_err <= 1'b0;
                  mif.resp_bus_err  <= !mif.bus_ack;
                  mif.resp_data     <= (mif.bus_ack && !r_store) ? w_res : r_addr32;
               end else begin
                  r_cnt <= r_cnt + 32'd1;
               end
            end
            S_RESP: begin
               r_state        <= S_IDLE;
               mif.resp_valid <= 1'b0;
               mif.req_ready  <= 1'b1;
               mif.busy       <= 1'b0;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end
endmodule
